// File: rtl/color_light_pkg.sv
// rtl/color_light_pkg.sv - shared state encoding and color mapping for the color sequencer
package color_light_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam int         NUM_COLORS = 7;
    localparam logic [2:0] LAST_IDX   = 3'(NUM_COLORS - 1);

    // Index 0..6 maps onto the seven non-black RGB codes 001..111.
    function automatic logic [2:0] idx_to_rgb(input logic [2:0] i);
        return i + 3'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV enabled cycles
module tick_gen #(
    parameter int TICK_DIV = 25_000_000,
    parameter int DIV_W    = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = en && !clr && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/color_seq_ctrl.sv
// rtl/color_seq_ctrl.sv - start/stop/pause sequencer stepping the lamp color index at a programmable dwell
module color_seq_ctrl
    import color_light_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int DIV_W    = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir,
    input  logic [1:0] hold_sel,
    output logic [2:0] rgb,
    output logic [2:0] idx,
    output logic       step,
    output logic       gene,
    output logic       busy
);

    state_t     state, state_d;
    logic [1:0] dwell, dwell_d;
    logic [1:0] limit, limit_d;
    logic [2:0] idx_d;
    logic       step_d, gene_d;
    logic       run_en, clr, tick;
    logic [2:0] idx_adv;
    logic       wrap;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (clr),
        .tick (tick)
    );

    // Explicit mod-7 neighbour; wrap is judged with the direction applied on this step.
    always_comb begin
        idx_adv = '0;
        wrap    = 1'b0;
        if (dir) begin
            wrap    = (idx == 3'd0);
            idx_adv = wrap ? LAST_IDX : idx - 3'd1;
        end else begin
            wrap    = (idx == LAST_IDX);
            idx_adv = wrap ? 3'd0 : idx + 3'd1;
        end
    end

    always_comb begin
        state_d = state;
        run_en  = 1'b0;
        clr     = 1'b0;
        idx_d   = idx;
        dwell_d = dwell;
        limit_d = limit;
        step_d  = 1'b0;
        gene_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
            idx_d   = 3'd0;
            dwell_d = 2'd0;
            limit_d = 2'd0;
        end else if (start) begin
            state_d = ST_RUN;
            clr     = 1'b1;
            idx_d   = dir ? LAST_IDX : 3'd0;
            dwell_d = 2'd0;
            limit_d = hold_sel;
        end else begin
            // Counters advance on every busy cycle with pause low, which keeps a pause exact.
            case (state)
                ST_RUN: begin
                    if (pause) state_d = ST_PAUSED;
                    else       run_en  = 1'b1;
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                        run_en  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (run_en && tick) begin
                if (dwell == limit) begin
                    idx_d   = idx_adv;
                    step_d  = 1'b1;
                    gene_d  = wrap;
                    dwell_d = 2'd0;
                    limit_d = hold_sel;
                end else begin
                    dwell_d = dwell + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
            dwell <= 2'd0;
            limit <= 2'd0;
            rgb   <= 3'd0;
            step  <= 1'b0;
            gene  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            dwell <= dwell_d;
            limit <= limit_d;
            step  <= step_d;
            gene  <= gene_d;
            busy  <= (state_d != ST_IDLE);
            rgb   <= (state_d == ST_IDLE) ? 3'd0 : idx_to_rgb(idx_d);
        end
    end

endmodule

// File: tb/tb_color_seq_ctrl.sv
// tb/tb_color_seq_ctrl.sv - randomized scoreboard bench for color_seq_ctrl against a cycle-countdown model
module tb_color_seq_ctrl;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] hold_sel = 2'd0;
    logic [2:0] rgb, idx;
    logic       step, gene, busy;

    color_seq_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .dir      (dir),
        .hold_sel (hold_sel),
        .rgb      (rgb),
        .idx      (idx),
        .step     (step),
        .gene     (gene),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int nidx;
        bit wrap;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  done     = 1'b0;

    // Reference: a busy sequencer is just "cycles left until the next color".
    bit  m_busy = 1'b0;
    int  m_idx  = 0;
    int  m_left = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_left = 0;
        q.delete();
    endtask

    task automatic model_edge(input bit s, input bit sp, input bit p, input bit d, input int h);
        ev_t e;
        if (sp) begin
            m_busy = 1'b0;
            m_idx  = 0;
        end else if (s) begin
            m_busy = 1'b1;
            m_idx  = d ? 6 : 0;
            m_left = TICK_DIV * (h + 1);
        end else if (m_busy && !p) begin
            m_left--;
            if (m_left == 0) begin
                e.cyc  = cyc;
                e.wrap = d ? (m_idx == 0) : (m_idx == 6);
                e.nidx = d ? (m_idx + 6) % 7 : (m_idx + 1) % 7;
                q.push_back(e);
                m_idx  = e.nidx;
                m_left = TICK_DIV * (h + 1);
            end
        end
    endtask

    task automatic drive_cycle(input bit s, input bit sp, input bit p, input bit d, input int h);
        @(negedge clk);
        start    = s;
        stop     = sp;
        pause    = p;
        dir      = d;
        hold_sel = 2'(h);
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_edge(s, sp, p, d, h);
    endtask

    task automatic idle_cycles(input int n, input bit p, input bit d, input int h);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, p, d, h);
    endtask

    always @(negedge clk) begin
        if (!done) begin
            check("busy", int'(busy), int'(m_busy));
            check("idx", int'(idx), m_idx);
            check("rgb", int'(rgb), m_busy ? m_idx + 1 : 0);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_step_cycle", 0, q[0].cyc);
                void'(q.pop_front());
            end
            if (step) begin
                if (q.size() == 0) begin
                    check("unexpected_step", 1, 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("step_cycle", cyc, e.cyc);
                    check("step_idx", int'(idx), e.nidx);
                    check("step_gene", int'(gene), int'(e.wrap));
                end
            end else begin
                check("gene_without_step", int'(gene), 0);
            end
        end
    end

    initial begin
        #1;
        check("rst_rgb", int'(rgb), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_step", int'(step), 0);
        check("rst_gene", int'(gene), 0);
        check("rst_busy", int'(busy), 0);
        drive_cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3, 0, 0, 0);

        // Ascending lap at hold 0: gene on 111->001 28 cycles after start.
        drive_cycle(1, 0, 0, 0, 0);
        idle_cycles(34, 0, 0, 0);
        // Restart while running returns to the first color without gene.
        drive_cycle(1, 0, 0, 0, 0);
        idle_cycles(10, 0, 0, 0);

        // Descending, hold 3.
        drive_cycle(1, 0, 0, 1, 3);
        idle_cycles(120, 0, 1, 3);

        // Pause held 10 cycles mid-dwell.
        drive_cycle(1, 0, 0, 0, 1);
        idle_cycles(5, 0, 0, 1);
        idle_cycles(10, 1, 0, 1);
        idle_cycles(20, 0, 0, 1);

        // Direction flipped before the first step at idx 0: 0->6 with gene.
        drive_cycle(1, 0, 0, 0, 0);
        idle_cycles(6, 0, 1, 0);

        // start and stop together while running.
        idle_cycles(3, 0, 1, 0);
        drive_cycle(1, 1, 0, 0, 0);
        idle_cycles(5, 0, 0, 0);

        // Asynchronous reset between clock edges.
        drive_cycle(1, 0, 0, 0, 2);
        idle_cycles(7, 0, 0, 2);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rgb", int'(rgb), 0);
        check("async_idx", int'(idx), 0);
        check("async_step", int'(step), 0);
        check("async_gene", int'(gene), 0);
        check("async_busy", int'(busy), 0);
        idle_cycles(2, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(8, 0, 0, 0);

        // Randomized control traffic.
        begin
            bit p = 1'b0;
            bit d = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit s, sp;
                s  = ($urandom_range(0, 59) == 0);
                sp = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 19) == 0) p = ~p;
                if ($urandom_range(0, 29) == 0) d = ~d;
                drive_cycle(s, sp, p, d, int'($urandom_range(0, 3)));
            end
        end

        idle_cycles(2, 0, 0, 0);
        @(posedge clk);
        done = 1'b1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
